// File: rtl/bitwise_op_pkg.sv
// Shared operation encoding for the bitwise/arithmetic unit.
package bitwise_op_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND   = 3'b000,
        OP_OR    = 3'b001,
        OP_XOR   = 3'b010,
        OP_NOR   = 3'b011,
        OP_ADD   = 3'b100,
        OP_ADDS  = 3'b101,
        OP_SUB   = 3'b110,
        OP_PASSB = 3'b111
    } op_e;

endpackage

// File: rtl/bitwise_op_unit_if.sv
// Input beat / output result handshake bundle for bitwise_op_unit.
interface bitwise_op_unit_if
    import bitwise_op_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [OP_W-1:0]  op;
    logic             acc_mode;
    logic             acc_clear;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             zero;
    logic [WIDTH-1:0] acc_q;

    // Producer of beats / consumer of results.
    modport master (
        output in_valid, a, b, op, acc_mode, acc_clear, out_ready,
        input  in_ready, out_valid, result, carry, zero, acc_q
    );

    // The operation unit itself.
    modport slave (
        input  in_valid, a, b, op, acc_mode, acc_clear, out_ready,
        output in_ready, out_valid, result, carry, zero, acc_q
    );

endinterface

// File: rtl/bitwise_op_core.sv
// Purely combinational datapath: one of eight bitwise/arithmetic ops.
module bitwise_op_core
    import bitwise_op_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  op_e              i_op,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_diff;

    // One extra bit catches the carry-out / borrow.
    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};

    // Operation select; logical ops always report carry = 0.
    always_comb begin
        o_result = '0;
        o_carry  = 1'b0;
        case (i_op)
            OP_AND:   o_result = i_a & i_b;
            OP_OR:    o_result = i_a | i_b;
            OP_XOR:   o_result = i_a ^ i_b;
            OP_NOR:   o_result = ~(i_a | i_b);
            OP_ADD: begin
                o_result = w_sum[WIDTH-1:0];
                o_carry  = w_sum[WIDTH];
            end
            OP_ADDS: begin
                o_carry  = w_sum[WIDTH];
                o_result = w_sum[WIDTH] ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
            end
            OP_SUB: begin
                // Top bit of the widened difference is set exactly when a < b.
                o_result = w_diff[WIDTH-1:0];
                o_carry  = w_diff[WIDTH];
            end
            OP_PASSB: o_result = i_b;
            default:  o_result = '0;
        endcase
    end

endmodule

// File: rtl/bitwise_op_unit.sv
// Registered bitwise/arithmetic unit with valid/ready handshake and
// optional running accumulator that can stand in for operand A.
module bitwise_op_unit
    import bitwise_op_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit ACC_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    bitwise_op_unit_if.slave  bus
);

    logic             w_accept;
    logic [WIDTH-1:0] w_operand_a;
    logic [WIDTH-1:0] w_core_result;
    logic             w_core_carry;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_zero;

    // A new beat may enter whenever the output slot is empty or being drained.
    assign bus.in_ready = !r_out_valid || bus.out_ready;
    assign w_accept     = bus.in_valid && bus.in_ready;

    bitwise_op_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .i_a      (w_operand_a),
        .i_b      (bus.b),
        .i_op     (op_e'(bus.op)),
        .o_result (w_core_result),
        .o_carry  (w_core_carry)
    );

    generate
        if (ACC_EN) begin : g_acc
            logic [WIDTH-1:0] r_acc;

            // Clear forces a zero operand; it wins over the accumulator feed.
            assign w_operand_a = bus.acc_clear ? '0 : (bus.acc_mode ? r_acc : bus.a);
            assign bus.acc_q   = r_acc;

            // Accumulator moves only on accepted beats, same edge as the output register.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_acc <= '0;
                end else if (w_accept) begin
                    if (bus.acc_mode) begin
                        r_acc <= w_core_result;
                    end else if (bus.acc_clear) begin
                        r_acc <= '0;
                    end
                end
            end
        end else begin : g_no_acc
            logic w_unused_acc_ctrl;

            assign w_operand_a       = bus.a;
            assign bus.acc_q         = '0;
            assign w_unused_acc_ctrl = bus.acc_mode | bus.acc_clear;
        end
    endgenerate

    // Output slot: load on accept, drop valid when consumed with nothing new arriving.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_carry     <= 1'b0;
            r_zero      <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_result    <= w_core_result;
            r_carry     <= w_core_carry;
            r_zero      <= (w_core_result == '0);
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.carry     = r_carry;
    assign bus.zero      = r_zero;

endmodule

// File: tb/tb_bitwise_op_unit.sv
// Scoreboard bench: two units (with and without accumulator) share one stimulus stream.
module tb_bitwise_op_unit;
    import bitwise_op_pkg::*;

    localparam int W = 8;

    logic clk;
    logic rst;

    bitwise_op_unit_if #(.WIDTH(W)) bus0 ();
    bitwise_op_unit_if #(.WIDTH(W)) bus1 ();

    bitwise_op_unit #(.WIDTH(W), .ACC_EN(1'b1)) u_dut_acc (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    bitwise_op_unit #(.WIDTH(W), .ACC_EN(1'b0)) u_dut_noacc (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    assign bus1.in_valid  = bus0.in_valid;
    assign bus1.a         = bus0.a;
    assign bus1.b         = bus0.b;
    assign bus1.op        = bus0.op;
    assign bus1.acc_mode  = bus0.acc_mode;
    assign bus1.acc_clear = bus0.acc_clear;
    assign bus1.out_ready = bus0.out_ready;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned res0;
        bit          cy0;
        int unsigned acc0;
        int unsigned res1;
        bit          cy1;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    int unsigned m_acc = 0;
    bit          ordy_rand = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
        end
    endfunction

    // Reference behaviour in plain integer arithmetic.
    function automatic void ref_op(input int unsigned aa, input int unsigned bb, input int o,
                                   output int unsigned res, output bit cy);
        int unsigned mx;
        mx  = (1 << W) - 1;
        res = 0;
        cy  = 1'b0;
        case (o)
            0: res = aa & bb;
            1: res = aa | bb;
            2: res = aa ^ bb;
            3: res = ~(aa | bb) & mx;
            4: begin res = (aa + bb) & mx; cy = (aa + bb) > mx; end
            5: begin
                if (aa + bb > mx) begin res = mx; cy = 1'b1; end
                else res = aa + bb;
            end
            6: begin res = (aa - bb) & mx; cy = aa < bb; end
            default: res = bb;
        endcase
    endfunction

    // Offer one beat until it is accepted; record its expected outcome.
    task automatic send(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic [2:0] oo,
                        input bit mode, input bit clr, input int stall);
        int          cyc;
        bit          done;
        int unsigned a_eff;
        exp_t        e;
        cyc  = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            bus0.in_valid  = 1'b1;
            bus0.a         = aa;
            bus0.b         = bb;
            bus0.op        = oo;
            bus0.acc_mode  = mode;
            bus0.acc_clear = clr;
            if (stall > 0) begin
                bus0.out_ready = 1'b0;
                stall--;
            end else begin
                bus0.out_ready = ordy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            #1;
            if (bus0.in_ready) begin
                a_eff = clr ? 0 : (mode ? m_acc : int'(aa));
                ref_op(a_eff, bb, oo, e.res0, e.cy0);
                if (mode) m_acc = e.res0;
                else if (clr) m_acc = 0;
                e.acc0 = m_acc;
                ref_op(aa, bb, oo, e.res1, e.cy1);
                sb.push_back(e);
                done = 1'b1;
            end else if (++cyc > 50) begin
                chk("accept_timeout", 32'd0, 32'd1);
                done = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        chk("latency_valid", bus0.out_valid, 1'b1);
    endtask

    // Cycle with no beat offered; acc_clear toggles to show it has no effect.
    task automatic idle();
        @(negedge clk);
        bus0.in_valid  = 1'b0;
        bus0.acc_clear = 1'($urandom_range(0, 1));
        bus0.acc_mode  = 1'($urandom_range(0, 1));
        bus0.out_ready = ordy_rand ? ($urandom_range(0, 1) != 0) : 1'b1;
    endtask

    // Monitor: compares each consumed result against the scoreboard, checks stall hold.
    bit             stall_prev = 1'b0;
    logic [W-1:0]   held_res;
    logic [W-1:0]   held_acc;
    logic           held_cy;
    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (!rst) begin
            chk("in_ready_rule", bus0.in_ready, !bus0.out_valid || bus0.out_ready);
            if (stall_prev && bus0.out_valid) begin
                chk("stall_result", bus0.result, held_res);
                chk("stall_carry", bus0.carry, held_cy);
                chk("stall_acc", bus0.acc_q, held_acc);
            end
            if (bus0.out_valid && bus0.out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    $display("out res=%02h cy=%0d z=%0d acc=%02h | noacc res=%02h cy=%0d",
                             bus0.result, bus0.carry, bus0.zero, bus0.acc_q,
                             bus1.result, bus1.carry);
                    chk("result", bus0.result, e.res0);
                    chk("carry", bus0.carry, e.cy0);
                    chk("zero", bus0.zero, e.res0 == 0);
                    chk("acc_q", bus0.acc_q, e.acc0);
                    chk("n_valid", bus1.out_valid, 1'b1);
                    chk("n_result", bus1.result, e.res1);
                    chk("n_carry", bus1.carry, e.cy1);
                    chk("n_zero", bus1.zero, e.res1 == 0);
                    chk("n_acc_q", bus1.acc_q, 0);
                end
            end
            stall_prev = bus0.out_valid && !bus0.out_ready;
            held_res   = bus0.result;
            held_cy    = bus0.carry;
            held_acc   = bus0.acc_q;
        end else begin
            stall_prev = 1'b0;
        end
    end

    initial begin
        rst            = 1'b1;
        bus0.in_valid  = 1'b0;
        bus0.a         = '0;
        bus0.b         = '0;
        bus0.op        = '0;
        bus0.acc_mode  = 1'b0;
        bus0.acc_clear = 1'b0;
        bus0.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valid", bus0.out_valid, 1'b0);
        chk("rst_result", bus0.result, 0);
        chk("rst_carry", bus0.carry, 1'b0);
        chk("rst_zero", bus0.zero, 1'b0);
        chk("rst_acc", bus0.acc_q, 0);
        @(negedge clk);
        rst = 1'b0;

        // Reset while a result is being held.
        @(negedge clk);
        bus0.in_valid  = 1'b1;
        bus0.a         = 8'h55;
        bus0.b         = 8'h0F;
        bus0.op        = 3'(OP_ADD);
        bus0.acc_mode  = 1'b1;
        bus0.acc_clear = 1'b0;
        bus0.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus0.in_valid = 1'b0;
        chk("pre_rst_valid", bus0.out_valid, 1'b1);
        chk("pre_rst_acc", bus0.acc_q, 8'h0F);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_valid", bus0.out_valid, 1'b0);
        chk("async_rst_result", bus0.result, 0);
        chk("async_rst_acc", bus0.acc_q, 0);
        sb.delete();
        m_acc = 0;
        @(negedge clk);
        rst = 1'b0;
        bus0.out_ready = 1'b1;

        // Logical op sweep.
        send(8'hF0, 8'h3C, 3'(OP_AND),   1'b0, 1'b0, 0);
        send(8'hF0, 8'h3C, 3'(OP_OR),    1'b0, 1'b0, 0);
        send(8'hF0, 8'h3C, 3'(OP_XOR),   1'b0, 1'b0, 0);
        send(8'hF0, 8'h3C, 3'(OP_NOR),   1'b0, 1'b0, 0);
        send(8'hF0, 8'h3C, 3'(OP_PASSB), 1'b0, 1'b0, 0);

        // Arithmetic boundaries.
        send(8'hFF, 8'h01, 3'(OP_ADD),  1'b0, 1'b0, 0);
        send(8'hF0, 8'h20, 3'(OP_ADDS), 1'b0, 1'b0, 0);
        send(8'h00, 8'h01, 3'(OP_SUB),  1'b0, 1'b0, 0);
        send(8'h05, 8'h05, 3'(OP_SUB),  1'b0, 1'b0, 0);

        // Accumulate chain 3, 7, 11.
        send(8'hAA, 8'h03, 3'(OP_ADD), 1'b1, 1'b1, 0);
        send(8'hAA, 8'h04, 3'(OP_ADD), 1'b1, 1'b0, 0);
        send(8'hAA, 8'h04, 3'(OP_ADD), 1'b1, 1'b0, 0);
        chk("chain_acc", bus0.acc_q, 8'd11);

        // Backpressure: three stalled cycles with an accumulate beat waiting.
        send(8'h00, 8'h01, 3'(OP_ADD), 1'b1, 1'b0, 0);
        send(8'h00, 8'h02, 3'(OP_ADD), 1'b1, 1'b0, 3);
        send(8'h00, 8'h05, 3'(OP_ADD), 1'b1, 1'b0, 0);

        // Build without accumulator ignores acc_mode.
        send(8'h12, 8'h01, 3'(OP_ADD), 1'b1, 1'b0, 0);
        chk("noacc_result", bus1.result, 8'h13);
        chk("noacc_acc", bus1.acc_q, 0);

        // Randomised traffic with random backpressure and idle gaps.
        ordy_rand = 1'b1;
        for (int i = 0; i < 200; i++) begin
            send(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
                 $urandom_range(0, 2) == 0, $urandom_range(0, 7) == 0,
                 ($urandom_range(0, 9) == 0) ? 2 : 0);
            if ($urandom_range(0, 3) == 0) idle();
        end

        // Drain remaining results.
        ordy_rand = 1'b0;
        @(negedge clk);
        bus0.in_valid  = 1'b0;
        bus0.acc_clear = 1'b0;
        bus0.out_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() != 0; i++) begin
            @(negedge clk);
            #3;
        end
        chk("drain_empty", sb.size(), 0);
        chk("final_acc", bus0.acc_q, m_acc);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
